// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis constants, FSM encoding and code helpers
// for the rate-1/2 K=3 (111/101) convolutional code.
package viterbi_pkg;
    localparam int NUM_STATES = 4;
    localparam int PM_INF = 8;
    typedef enum logic [1:0] {ACS, TRACE, EMIT} state_t;
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic u);
        return {u, s[1]};
    endfunction
    function automatic logic [1:0] exp_sym(input logic [1:0] s, input logic u);
        return {u ^ s[1] ^ s[0], u ^ s[0]};
    endfunction
    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        return 2'(a[1] ^ b[1]) + 2'(a[0] ^ b[0]);
    endfunction
endpackage

// File: rtl/viterbi_decoder_if.sv
// viterbi_decoder_if: symbol input handshake and decoded-bit output bundle.
interface viterbi_decoder_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       frame_done;
    logic       busy;
    modport master (output sym_in, sym_valid, input sym_ready, bit_out, bit_valid, frame_done, busy);
    modport slave  (input sym_in, sym_valid, output sym_ready, bit_out, bit_valid, frame_done, busy);
endinterface

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select for one trellis state; ties pick predecessor s0=0.
module viterbi_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [1:0]      i_bm0,
    input  logic [1:0]      i_bm1,
    output logic [PM_W-1:0] o_pm,
    output logic            o_dec
);
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;
    assign w_c0  = i_pm0 + PM_W'(i_bm0);
    assign w_c1  = i_pm1 + PM_W'(i_bm1);
    assign o_dec = w_c1 < w_c0;
    assign o_pm  = o_dec ? w_c1 : w_c0;
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder, frame-based ACS, traceback from
// state 00, then serial emission of decoded bits oldest first.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 6,
    parameter int PM_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    viterbi_decoder_if.slave  bus
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [PM_W-1:0]       r_pm [NUM_STATES];
    logic [PM_W-1:0]       w_pm [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic [NUM_STATES-1:0] r_surv [FRAME_LEN];
    logic [FRAME_LEN-1:0]  r_dec;
    logic [1:0]            r_cur;
    logic r_ready, r_valid, r_bit, r_done, r_busy;
    logic w_acc, w_valid, w_bit, w_done;

    // next state {u,p} is reached from {p,0} and {p,1} with input u
    genvar n;
    for (n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic       U  = 1'(n / 2);
        localparam logic [1:0] S0 = 2'(2 * (n % 2));
        localparam logic [1:0] S1 = 2'(2 * (n % 2) + 1);
        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .i_pm0 (r_pm[S0]),
            .i_pm1 (r_pm[S1]),
            .i_bm0 (hamming(bus.sym_in, exp_sym(S0, U))),
            .i_bm1 (hamming(bus.sym_in, exp_sym(S1, U))),
            .o_pm  (w_pm[n]),
            .o_dec (w_dec[n])
        );
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_acc   = 1'b0;
        w_valid = 1'b0;
        w_bit   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ACS: begin
                w_acc = bus.sym_valid && r_ready;
                if (w_acc) begin
                    w_state = r_cnt == LAST ? TRACE : ACS;
                    w_cnt   = r_cnt == LAST ? LAST : r_cnt + 1'b1;
                end
            end
            TRACE: begin
                w_state = r_cnt == '0 ? EMIT : TRACE;
                w_cnt   = r_cnt == '0 ? '0 : r_cnt - 1'b1;
                w_valid = r_cnt == '0;
                w_bit   = r_cnt == '0 && r_cur[1];
            end
            EMIT: begin
                w_state = r_cnt == LAST ? ACS : EMIT;
                w_cnt   = r_cnt == LAST ? '0 : r_cnt + 1'b1;
                w_valid = r_cnt != LAST;
                w_bit   = r_cnt != LAST && r_dec[r_cnt + 1'b1];
                w_done  = r_cnt != LAST && (r_cnt + 1'b1 == LAST);
            end
            default: w_state = ACS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACS;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ready <= w_state == ACS;
            r_valid <= w_valid;
            r_bit   <= w_bit;
            r_done  <= w_done;
            r_busy  <= w_state != ACS;
            if (w_acc) r_surv[r_cnt] <= w_dec;
            // traceback walks predecessors: {u,p} came from {p, decision}
            if (r_state == TRACE) begin
                r_dec[r_cnt] <= r_cur[1];
                r_cur        <= {r_cur[0], r_surv[r_cnt][r_cur]};
            end else begin
                r_cur <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == EMIT && r_cnt == LAST)) begin
            for (int i = 0; i < NUM_STATES; i++) r_pm[i] <= i == 0 ? '0 : PM_W'(PM_INF);
        end else if (w_acc) begin
            r_pm <= w_pm;
        end
    end

    assign bus.sym_ready  = r_ready;
    assign bus.bit_out    = r_bit;
    assign bus.bit_valid  = r_valid;
    assign bus.frame_done = r_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: scenario tasks with a queue scoreboard of expected decoded bits.
module tb_viterbi_decoder;
    localparam int FL = 6;
    typedef logic [1:0] frame_t [FL];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    viterbi_decoder_if bus ();
    viterbi_decoder #(.FRAME_LEN(FL), .PM_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_frame(input frame_t f, input bit gapped, output int last_acc);
        int  i = 0;
        int  guard = 0;
        bit  ph = 1'b0;
        last_acc = -1;
        while (i < FL && guard < 4 * FL + 40) begin
            @(negedge clk);
            guard++;
            bus.sym_in    = f[i];
            bus.sym_valid = gapped ? ph : 1'b1;
            ph = !ph;
            if (bus.sym_valid && bus.sym_ready) begin
                last_acc = cyc;
                i++;
            end
        end
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    task automatic capture(output logic [31:0] bits, output int n, output int first_c,
                           output int done_c, output int taken);
        int guard = 0;
        bits = '0; n = 0; first_c = -1; done_c = -1; taken = 0;
        while (done_c < 0 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (bus.sym_valid && bus.sym_ready) taken++;
            if (bus.bit_valid) begin
                if (n == 0) first_c = cyc;
                if (n < 32) bits[n] = bus.bit_out;
                n++;
            end
            if (bus.frame_done) done_c = cyc;
        end
    endtask

    task automatic encode(input logic [FL-1:0] data, output frame_t f);
        logic s1 = 1'b0;
        logic s0 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            f[i] = {data[i] ^ s1 ^ s0, data[i] ^ s0};
            s0 = s1;
            s1 = data[i];
        end
    endtask

    task automatic test_reset();
        bus.sym_in = 2'b00; bus.sym_valid = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.sym_ready, bus.bit_out, bus.bit_valid, bus.frame_done, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.sym_ready, bus.bit_out, bus.bit_valid, bus.frame_done, bus.busy});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", bus.sym_ready);
        end
    endtask

    task automatic test_clean();
        frame_t f = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11};
        logic [FL-1:0] eb = 6'b001110;
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(eb[i]);
        drive_frame(f, 1'b0, la);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_trace_flags: got busy=%b ready=%b expected busy=1 ready=0", bus.busy, bus.sym_ready);
        end
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL clean_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL clean_bit%0d: got %b expected %b", i, bits[i], e); end
        end
        n_checks++;
        if (fc - la !== FL + 1) begin n_fail++; $display("FAIL clean_first_latency: got %0d expected %0d", fc - la, FL + 1); end
        n_checks++;
        if (dc - la !== 2 * FL) begin n_fail++; $display("FAIL clean_done_latency: got %0d expected %0d", dc - la, 2 * FL); end
        @(negedge clk);
        n_checks++;
        if (bus.sym_ready !== 1'b1 || bus.busy !== 1'b0 || bus.bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_return: got ready=%b busy=%b valid=%b expected 1 0 0", bus.sym_ready, bus.busy, bus.bit_valid);
        end
    endtask

    task automatic test_single_error();
        frame_t f = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11};
        logic [FL-1:0] eb = 6'b001110;
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(eb[i]);
        drive_frame(f, 1'b0, la);
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL err_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL err_bit%0d: got %b expected %b", i, bits[i], e); end
        end
    endtask

    task automatic test_all_zero();
        frame_t f = '{default: 2'b00};
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(1'b0);
        drive_frame(f, 1'b0, la);
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL zero_bit%0d: got %b expected %b", i, bits[i], e); end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1 = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
        frame_t f2;
        logic [FL-1:0] d2 = 6'b001101;
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        encode(d2, f2);
        drive_frame(f1, 1'b0, la);
        bus.sym_in = f2[0];
        bus.sym_valid = 1'b1;
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (tk !== 0) begin n_fail++; $display("FAIL bp_consumed: got %0d expected 0", tk); end
        n_checks++;
        if (dc < 0) begin n_fail++; $display("FAIL bp_frame1_done: got %0d expected done cycle", dc); end
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(d2[i]);
        drive_frame(f2, 1'b0, la);
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL bp_bit%0d: got %b expected %b", i, bits[i], e); end
        end
    endtask

    task automatic test_mid_reset();
        frame_t f = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11};
        logic [FL-1:0] eb = 6'b001110;
        logic [31:0] bits;
        int n, fc, dc, tk, la, seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.sym_in = f[i];
            bus.sym_valid = 1'b1;
        end
        @(negedge clk);
        bus.sym_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.sym_ready, bus.bit_out, bus.bit_valid, bus.frame_done, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b expected 00000",
                     {bus.sym_ready, bus.bit_out, bus.bit_valid, bus.frame_done, bus.busy});
        end
        reset = 1'b0;
        seen = 0;
        repeat (3 * FL) begin
            @(negedge clk);
            if (bus.bit_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d expected 0", seen); end
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(eb[i]);
        drive_frame(f, 1'b0, la);
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL midrst_bit%0d: got %b expected %b", i, bits[i], e); end
        end
    endtask

    task automatic test_gapped();
        frame_t f = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11};
        logic [FL-1:0] eb = 6'b001110;
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        exp_q.delete();
        for (int i = 0; i < FL; i++) exp_q.push_back(eb[i]);
        drive_frame(f, 1'b1, la);
        capture(bits, n, fc, dc, tk);
        n_checks++;
        if (n !== FL) begin n_fail++; $display("FAIL gap_count: got %0d expected %0d", n, FL); end
        for (int i = 0; i < FL; i++) begin
            logic e = exp_q.pop_front();
            n_checks++;
            if (bits[i] !== e) begin n_fail++; $display("FAIL gap_bit%0d: got %b expected %b", i, bits[i], e); end
        end
        n_checks++;
        if (fc - la !== FL + 1) begin n_fail++; $display("FAIL gap_first_latency: got %0d expected %0d", fc - la, FL + 1); end
        n_checks++;
        if (dc - la !== 2 * FL) begin n_fail++; $display("FAIL gap_done_latency: got %0d expected %0d", dc - la, 2 * FL); end
    endtask

    task automatic test_random();
        frame_t f;
        logic [FL-1:0] d;
        logic [31:0] bits;
        int n, fc, dc, tk, la;
        repeat (8) begin
            d = FL'($urandom_range(0, (1 << (FL - 2)) - 1));
            encode(d, f);
            exp_q.delete();
            for (int i = 0; i < FL; i++) exp_q.push_back(d[i]);
            drive_frame(f, 1'b0, la);
            capture(bits, n, fc, dc, tk);
            n_checks++;
            if (n !== FL) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", n, FL); end
            for (int i = 0; i < FL; i++) begin
                logic e = exp_q.pop_front();
                n_checks++;
                if (bits[i] !== e) begin n_fail++; $display("FAIL rand_bit%0d data=%b: got %b expected %b", i, d, bits[i], e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_all_zero();
        test_back_to_back();
        test_mid_reset();
        test_gapped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
